// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// serial_tx_pkg : state encoding and parity helper shared by the serial TX.
// Revision: 1.0
// ============================================================================
package serial_tx_pkg;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int MAX_WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } tx_state_t;

  function automatic logic even_parity(input logic [MAX_WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_period_timer.sv
`default_nettype none
// ============================================================================
// bit_period_timer : counts CLKS_PER_BIT cycles per bit while run is high;
// tick marks the last cycle of each bit period.
// Revision: 1.0
// ============================================================================
module bit_period_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_cnt;

  // Held at zero while idle so every frame starts on a fresh bit period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!run || (div_cnt == LAST_DIV)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = run && (div_cnt == LAST_DIV);

endmodule
`default_nettype wire

// File: rtl/serial_word_transmitter.sv
`default_nettype none
// ============================================================================
// serial_word_transmitter : ready/valid parallel word in, serial bits out with
// a one-cycle shift strobe per bit. Macro SERIAL_TX_PARITY_EN adds an even-parity bit.
// Revision: 1.0
// ============================================================================
module serial_word_transmitter
  import serial_tx_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_serial,
  output logic         o_shift_ena,
  output logic         o_busy,
  output logic         o_done
);
  localparam int BIT_W = $clog2(N + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [N-1:0]     hold;
  logic [N-1:0]     hold_shifted;
  logic [BIT_W-1:0] bit_cnt;
  logic             head_bit;
  logic             tick;
  logic             run;
  logic             accept;
  logic             last_bit;

  assign accept   = i_valid && (state == IDLE);
  assign last_bit = tick && (bit_cnt == LAST_BIT);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign head_bit     = hold[N-1];
      assign hold_shifted = {hold[N-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit     = hold[0];
      assign hold_shifted = {1'b0, hold[N-1:1]};
    end
  endgenerate

`ifdef SERIAL_TX_PARITY_EN
  logic [MAX_WORD_W-1:0] data_ext;
  logic                  parity_bit;

  assign data_ext = MAX_WORD_W'(i_data);
  assign run      = (state == SHIFT) || (state == PARITY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= even_parity(data_ext);
    end
  end
`else
  assign run = (state == SHIFT);
`endif

  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      hold    <= i_data;
      bit_cnt <= '0;
    end else if ((state == SHIFT) && tick) begin
      hold    <= hold_shifted;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    o_serial   = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) state_next = SHIFT;
      end
      SHIFT: begin
        o_serial = head_bit;
`ifdef SERIAL_TX_PARITY_EN
        if (last_bit) state_next = PARITY;
`else
        if (last_bit) state_next = DONE;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        o_serial = parity_bit;
        if (tick) state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_shift_ena = tick;
  assign o_ready     = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);

endmodule
`default_nettype wire
